// File: rtl/tlb_walker.sv
// Page-table walker: answers TLB misses by reading one PTE from memory and
// returning a fill (physical page or fault) over a valid/ready handshake.
`ifndef PAGE_WIDTH
`define PAGE_WIDTH 20
`endif

module tlb_walker #(
  parameter int                    WIDTH      = `PAGE_WIDTH,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PT_BASE    = ADDR_WIDTH'(32'h0001_0000)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [WIDTH-1:0]      miss_vpn,
  output logic                  miss_ready,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data,
  output logic                  fill_valid,
  output logic [WIDTH-1:0]      fill_vpn,
  output logic [WIDTH-1:0]      fill_ppn,
  output logic                  fill_fault,
  input  logic                  fill_ready,
  output logic [15:0]           walk_count,
  output logic [15:0]           fault_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

  // Wide enough that vpn << 2 never loses bits before the final truncation.
  localparam int SUM_W = (ADDR_WIDTH > WIDTH + 2) ? ADDR_WIDTH : WIDTH + 2;

  state_t           state, state_n;
  logic [WIDTH-1:0] vpn_q;
  logic [WIDTH-1:0] ppn_q;
  logic             pte_valid_q;
  logic [15:0]      walk_count_q;
  logic [15:0]      fault_count_q;
  logic [SUM_W-1:0] addr_sum;
  logic             miss_hs;
  logic             resp_take;
  logic             fill_hs;

  // Only PTE bits [WIDTH:0] and the low ADDR_WIDTH bits of the sum matter.
  logic pte_unused;
  logic addr_unused;
  assign pte_unused  = ^mem_resp_data;
  assign addr_unused = ^addr_sum;

  assign addr_sum  = SUM_W'(PT_BASE) + (SUM_W'(vpn_q) << 2);
  assign miss_hs   = (state == S_IDLE) && miss_valid;
  assign resp_take = (state == S_WAIT) && mem_resp_valid;
  assign fill_hs   = (state == S_FILL) && fill_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      vpn_q         <= '0;
      ppn_q         <= '0;
      pte_valid_q   <= 1'b0;
      walk_count_q  <= '0;
      fault_count_q <= '0;
    end else begin
      state <= state_n;
      if (miss_hs) vpn_q <= miss_vpn;
      if (resp_take) begin
        pte_valid_q <= mem_resp_data[0];
        ppn_q       <= mem_resp_data[WIDTH:1];
      end
      if (fill_hs) begin
        if (walk_count_q != 16'hFFFF) walk_count_q <= walk_count_q + 16'd1;
        if (!pte_valid_q && fault_count_q != 16'hFFFF)
          fault_count_q <= fault_count_q + 16'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    fill_valid    = 1'b0;
    fill_vpn      = '0;
    fill_ppn      = '0;
    fill_fault    = 1'b0;
    unique case (state)
      S_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_n = S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_sum[ADDR_WIDTH-1:0];
        if (mem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) state_n = S_FILL;
      end
      S_FILL: begin
        fill_valid = 1'b1;
        fill_vpn   = vpn_q;
        fill_fault = !pte_valid_q;
        fill_ppn   = pte_valid_q ? ppn_q : '0;
        if (fill_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign walk_count  = walk_count_q;
  assign fault_count = fault_count_q;

endmodule
